// File: rtl/multdiv_sequencer.sv
// Sequencer between the execute stage and an iterative multiply/divide unit.
// It accepts one operation at a time and holds the operands stable for the
// unit. It stalls the pipeline while the unit works, and it forces completion
// with an exception if the unit does not answer within TIMEOUT cycles.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for an issue; an accepted issue already stalls the pipe
// RUN   | unit busy; cnt counts RUN cycles, start pulse is sent at cnt==0
// DONE  | one-cycle result presentation, always returns to IDLE
module multdiv_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int DW      = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          issue_mult,
  input  logic          issue_div,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  input  logic          kill,
  output logic          unit_start_mult,
  output logic          unit_start_div,
  output logic [DW-1:0] unit_a,
  output logic [DW-1:0] unit_b,
  input  logic [DW-1:0] unit_result,
  input  logic          unit_exception,
  input  logic          unit_ready,
  output logic          stall,
  output logic [DW-1:0] result,
  output logic          exception,
  output logic          result_valid,
  output logic          busy,
  output logic          timeout_flag
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] unit_a_q, unit_a_d;
  logic [DW-1:0] unit_b_q, unit_b_d;
  logic [DW-1:0] result_q, result_d;
  logic          exception_q, exception_d;
  logic          timeout_flag_q, timeout_flag_d;
  logic          start_mult_q, start_mult_d;
  logic          start_div_q, start_div_d;

  logic issue_any;
  logic accept;

  // Acceptance happens only in IDLE; a simultaneous kill drops the issue.
  always_comb begin
    issue_any = issue_mult | issue_div;
    accept    = (state_q == S_IDLE) & issue_any & ~kill;
  end

  // Next-state and datapath capture for the three-state sequencer.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    unit_a_d       = unit_a_q;
    unit_b_d       = unit_b_q;
    result_d       = result_q;
    exception_d    = exception_q;
    timeout_flag_d = timeout_flag_q;
    start_mult_d   = 1'b0;
    start_div_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d      = S_RUN;
          cnt_d        = '0;
          unit_a_d     = op_a;
          unit_b_d     = op_b;
          // Multiply takes precedence when both issue lines are high.
          start_mult_d = issue_mult;
          start_div_d  = ~issue_mult;
        end
      end

      S_RUN: begin
        if (kill) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (unit_ready && (cnt_q != '0)) begin
          // The ready line is ignored in the start-pulse cycle. A ready seen
          // on the timeout cycle still wins, so the watchdog stays quiet.
          state_d     = S_DONE;
          result_d    = unit_result;
          exception_d = unit_exception;
          cnt_d       = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d        = S_DONE;
          result_d       = '0;
          exception_d    = 1'b1;
          timeout_flag_d = 1'b1;
          cnt_d          = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      unit_a_q       <= '0;
      unit_b_q       <= '0;
      result_q       <= '0;
      exception_q    <= 1'b0;
      timeout_flag_q <= 1'b0;
      start_mult_q   <= 1'b0;
      start_div_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      unit_a_q       <= unit_a_d;
      unit_b_q       <= unit_b_d;
      result_q       <= result_d;
      exception_q    <= exception_d;
      timeout_flag_q <= timeout_flag_d;
      start_mult_q   <= start_mult_d;
      start_div_q    <= start_div_d;
    end
  end

  // Output decode. Stall is combinational so the accepting cycle freezes the
  // pipe. It is forced low while reset is held.
  always_comb begin
    busy            = (state_q == S_RUN);
    result_valid    = (state_q == S_DONE);
    stall           = reset & (accept | busy);
    unit_start_mult = start_mult_q;
    unit_start_div  = start_div_q;
    unit_a          = unit_a_q;
    unit_b          = unit_b_q;
    result          = result_q;
    exception       = exception_q;
    timeout_flag    = timeout_flag_q;
  end

endmodule
